// File: rtl/shift_fifo_p_if.sv
// Handshake bundle for shift_fifo_p: write/read/flush requests in,
// head data, occupancy and sticky error flags out.
interface shift_fifo_p_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 6
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] D;
  logic             WR;
  logic             RD;
  logic             FLUSH;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             FULL;
  logic             AFULL;
  logic [CW-1:0]    COUNT;
  logic             OVF;
  logic             UNF;

  modport master (
    output D, WR, RD, FLUSH,
    input  Q, VALID, FULL, AFULL, COUNT, OVF, UNF
  );

  modport slave (
    input  D, WR, RD, FLUSH,
    output Q, VALID, FULL, AFULL, COUNT, OVF, UNF
  );
endinterface

// File: rtl/shift_fifo_p.sv
// Shift-register FIFO: slot 0 is the registered head, valid flags form a
// thermometer from slot 0, pushes land in the first slot free after the shift.
module shift_fifo_p #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 6,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2
) (
  input  logic           CLK,
  input  logic           RST,
  shift_fifo_p_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [DEPTH-1:0] vld, vld_nxt;
  logic [CW-1:0]    count, count_nxt, wr_slot;
  logic             ovf, unf;
  logic             pop, push;

  assign pop     = bus.RD & vld[0];
  assign push    = bus.WR & (~vld[DEPTH-1] | pop);
  assign wr_slot = count - CW'(pop);

  // Data only moves into a slot whose new occupant is valid, so the head
  // keeps its last value once the final entry has been popped.
  always_comb begin
    mem_nxt   = mem;
    vld_nxt   = vld;
    count_nxt = count + CW'(push) - CW'(pop);
    if (pop) begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) begin
        vld_nxt[k] = vld[k+1];
        if (vld[k+1]) mem_nxt[k] = mem[k+1];
      end
      vld_nxt[DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (wr_slot == CW'(k)) begin
          mem_nxt[k] = bus.D;
          vld_nxt[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
      vld   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (bus.FLUSH) begin
      vld   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      mem   <= mem_nxt;
      vld   <= vld_nxt;
      count <= count_nxt;
      if (bus.WR && !push) ovf <= 1'b1;
      if (bus.RD && !vld[0]) unf <= 1'b1;
    end
  end

  assign bus.Q     = mem[0];
  assign bus.VALID = vld[0];
  assign bus.FULL  = vld[DEPTH-1];
  assign bus.AFULL = (count >= CW'(AFULL_LEVEL));
  assign bus.COUNT = count;
  assign bus.OVF   = ovf;
  assign bus.UNF   = unf;
endmodule

// File: tb/tb_shift_fifo_p.sv
// Bench for shift_fifo_p: directed scenarios on an 8x6 instance plus random
// traffic on 1x2 and 32x16 instances, all checked against a queue model.
module tb_shift_fifo_p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_fifo_p_if #(.WIDTH(8),  .DEPTH(6))  a ();
  shift_fifo_p_if #(.WIDTH(1),  .DEPTH(2))  b ();
  shift_fifo_p_if #(.WIDTH(32), .DEPTH(16)) c ();

  shift_fifo_p #(.WIDTH(8),  .DEPTH(6))                    dut_a (.CLK(clk), .RST(rst), .bus(a));
  shift_fifo_p #(.WIDTH(1),  .DEPTH(2),  .AFULL_LEVEL(1))  dut_b (.CLK(clk), .RST(rst), .bus(b));
  shift_fifo_p #(.WIDTH(32), .DEPTH(16))                   dut_c (.CLK(clk), .RST(rst), .bus(c));

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned sel = 0, m_depth = 6, m_afl = 4;
  logic [31:0] mq[$];
  bit          m_ovf = 0, m_unf = 0;
  logic [31:0] o_q, o_count;
  logic        o_valid, o_full, o_afull, o_ovf, o_unf;

  function automatic logic [31:0] dmask();
    case (sel)
      0:       return 32'h0000_00FF;
      1:       return 32'h0000_0001;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic idle();
    a.WR = 0; a.RD = 0; a.FLUSH = 0; a.D = '0;
    b.WR = 0; b.RD = 0; b.FLUSH = 0; b.D = '0;
    c.WR = 0; c.RD = 0; c.FLUSH = 0; c.D = '0;
  endtask

  task automatic sample();
    case (sel)
      0: begin o_q = 32'(a.Q); o_count = 32'(a.COUNT); o_valid = a.VALID; o_full = a.FULL;
               o_afull = a.AFULL; o_ovf = a.OVF; o_unf = a.UNF; end
      1: begin o_q = 32'(b.Q); o_count = 32'(b.COUNT); o_valid = b.VALID; o_full = b.FULL;
               o_afull = b.AFULL; o_ovf = b.OVF; o_unf = b.UNF; end
      default: begin o_q = c.Q; o_count = 32'(c.COUNT); o_valid = c.VALID; o_full = c.FULL;
               o_afull = c.AFULL; o_ovf = c.OVF; o_unf = c.UNF; end
    endcase
  endtask

  // One clock of stimulus on the selected instance; the model queue is updated alongside.
  task automatic cyc(input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    bit pop, push;
    case (sel)
      0: begin a.WR = wr; a.D = d[7:0]; a.RD = rd; a.FLUSH = fl; end
      1: begin b.WR = wr; b.D = d[0];   b.RD = rd; b.FLUSH = fl; end
      default: begin c.WR = wr; c.D = d; c.RD = rd; c.FLUSH = fl; end
    endcase
    if (fl) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      pop  = rd && (mq.size() != 0);
      push = wr && ((mq.size() < m_depth) || pop);
      if (rd && !pop) m_unf = 1;
      if (wr && !push) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d & dmask());
    end
    @(posedge clk); #1;
    idle();
    sample();
  endtask

  task automatic test_reset();
    sel = 0; m_depth = 6; m_afl = 4;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    sample();
    n_chk++; if (o_count !== 0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_chk++; if (o_valid !== 0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_chk++; if (o_q !== 0)      begin n_fail++; $display("FAIL reset_q: got %h want 0", o_q); end
    n_chk++; if ({o_full, o_ovf, o_unf} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags: got full/ovf/unf=%b want 000", {o_full, o_ovf, o_unf}); end
    @(negedge clk); rst = 1'b0;
    mq.delete(); m_ovf = 0; m_unf = 0;
    cyc(1, 32'hA5, 0, 0);
    n_chk++; if (o_valid !== 1)  begin n_fail++; $display("FAIL first_valid: got %b want 1", o_valid); end
    n_chk++; if (o_q !== 32'hA5) begin n_fail++; $display("FAIL first_q: got %h want a5", o_q); end
    n_chk++; if (o_count !== 1)  begin n_fail++; $display("FAIL first_count: got %0d want 1", o_count); end
    n_chk++; if (o_full !== 0)   begin n_fail++; $display("FAIL first_full: got %b want 0", o_full); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 32'(i), 0, 0);
      n_chk++; if (o_count !== 32'(i)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", o_count, i); end
      n_chk++; if (o_afull !== (i >= 4)) begin n_fail++; $display("FAIL fill_afull: got %b want %b at count %0d", o_afull, (i >= 4), i); end
      n_chk++; if (o_full !== (i == 6))  begin n_fail++; $display("FAIL fill_full: got %b want %b at count %0d", o_full, (i == 6), i); end
    end
    cyc(1, 32'h07, 0, 0);
    n_chk++; if (o_ovf !== 1)   begin n_fail++; $display("FAIL ovf_set: got %b want 1", o_ovf); end
    n_chk++; if (o_count !== 6) begin n_fail++; $display("FAIL ovf_count: got %0d want 6", o_count); end
    for (int i = 1; i <= 6; i++) begin
      n_chk++; if (o_q !== 32'(i)) begin n_fail++; $display("FAIL drain_q: got %h want %h", o_q, i); end
      cyc(0, 0, 1, 0);
    end
    n_chk++; if (o_valid !== 0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", o_valid); end
    n_chk++; if (o_ovf !== 1)   begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", o_ovf); end
    cyc(0, 0, 0, 1);
    n_chk++; if (o_ovf !== 0)   begin n_fail++; $display("FAIL ovf_flush: got %b want 0", o_ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp3 [6];
    exp3 = '{8'h04, 8'h05, 8'h06, 8'h77, 8'h77, 8'h77};
    for (int i = 1; i <= 6; i++) cyc(1, 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h77, 1, 0);
      n_chk++; if (o_count !== 6) begin n_fail++; $display("FAIL pp_count: got %0d want 6", o_count); end
      n_chk++; if (o_ovf !== 0)   begin n_fail++; $display("FAIL pp_ovf: got %b want 0", o_ovf); end
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (o_q !== 32'(exp3[i])) begin n_fail++; $display("FAIL pp_order: got %h want %h", o_q, exp3[i]); end
      cyc(0, 0, 1, 0);
    end
    n_chk++; if (o_count !== 0) begin n_fail++; $display("FAIL pp_empty: got %0d want 0", o_count); end
  endtask

  task automatic test_empty_wr_rd();
    cyc(1, 32'h3C, 1, 0);
    n_chk++; if (o_unf !== 1)    begin n_fail++; $display("FAIL ewr_unf: got %b want 1", o_unf); end
    n_chk++; if (o_count !== 1)  begin n_fail++; $display("FAIL ewr_count: got %0d want 1", o_count); end
    n_chk++; if (o_q !== 32'h3C) begin n_fail++; $display("FAIL ewr_q: got %h want 3c", o_q); end
    cyc(0, 0, 1, 0);
    n_chk++; if (o_count !== 0)  begin n_fail++; $display("FAIL ewr_pop: got %0d want 0", o_count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) cyc(1, 32'h40 + 32'(i), 0, 0);
    n_chk++; if (o_count !== 4) begin n_fail++; $display("FAIL fl_pre: got %0d want 4", o_count); end
    cyc(1, 32'h99, 0, 1);
    n_chk++; if (o_count !== 0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", o_count); end
    n_chk++; if (o_valid !== 0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", o_valid); end
    n_chk++; if ({o_ovf, o_unf} !== 2'b00) begin n_fail++; $display("FAIL fl_err: got ovf/unf=%b want 00", {o_ovf, o_unf}); end
    n_chk++; if (o_q !== 32'h40) begin n_fail++; $display("FAIL fl_qhold: got %h want 40", o_q); end
    cyc(1, 32'h5A, 0, 0);
    n_chk++; if (o_count !== 1)  begin n_fail++; $display("FAIL fl_after: got %0d want 1", o_count); end
    n_chk++; if (o_q !== 32'h5A) begin n_fail++; $display("FAIL fl_after_q: got %h want 5a", o_q); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'h20 + 32'(i), 0, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1; sample();
    mq.delete(); m_ovf = 0; m_unf = 0;
    n_chk++; if (o_count !== 0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", o_count); end
    n_chk++; if (o_valid !== 0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", o_valid); end
    n_chk++; if (o_q !== 0)     begin n_fail++; $display("FAIL ar_q: got %h want 0", o_q); end
    @(negedge clk); rst = 1'b0;
    cyc(1, 32'h11, 0, 0);
    n_chk++; if (o_q !== 32'h11) begin n_fail++; $display("FAIL ar_q2: got %h want 11", o_q); end
    n_chk++; if (o_count !== 1)  begin n_fail++; $display("FAIL ar_count2: got %0d want 1", o_count); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_random(input int unsigned s, input int unsigned depth,
                             input int unsigned afl, input int unsigned ncyc);
    int unsigned pw, pr;
    sel = s; m_depth = depth; m_afl = afl;
    cyc(0, 0, 0, 1);
    for (int unsigned i = 0; i < ncyc; i++) begin
      pw = (i % 200 < 100) ? 70 : 35;
      pr = (i % 200 < 100) ? 35 : 70;
      cyc($urandom_range(0, 99) < pw, $urandom(), $urandom_range(0, 99) < pr,
          $urandom_range(0, 99) < 2);
      n_chk++; if (o_count !== 32'(mq.size())) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", s, o_count, mq.size()); end
      n_chk++; if (o_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd%0d_valid: got %b want %b", s, o_valid, (mq.size() != 0)); end
      n_chk++; if (o_full !== (mq.size() == depth)) begin n_fail++; $display("FAIL rnd%0d_full: got %b want %b", s, o_full, (mq.size() == depth)); end
      n_chk++; if (o_afull !== (mq.size() >= afl)) begin n_fail++; $display("FAIL rnd%0d_afull: got %b want %b", s, o_afull, (mq.size() >= afl)); end
      n_chk++; if ({o_ovf, o_unf} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", s, {o_ovf, o_unf}, {m_ovf, m_unf}); end
      if (mq.size() != 0) begin
        n_chk++; if (o_q !== mq[0]) begin n_fail++; $display("FAIL rnd%0d_q: got %h want %h", s, o_q, mq[0]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_wr_rd();
    test_flush();
    test_async_reset();
    test_random(1, 2, 1, 400);
    test_random(2, 16, 14, 800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
